tr_arbiter: RTL and testbench
=============================

// Module: tr_arbiter
// PURPOSE
//  Parametrised arbiter over NUM_TR transaction-ID ready lines in the relational cache.
//  Selects one ready transaction and presents its ID on a registered valid/accept handshake.
//  Runtime-selectable fixed-priority (highest index wins) or round-robin mode.
//  Sits between the per-TRID ready flags and the shared downstream datapath mux.
// PARAMETERS
//  NUM_TR  16                  number of transaction-ID request lines (>=2)
//  SEL_W   $clog2(NUM_TR)      width of the selected ID (derived; do not override)
// PORTS
//  i_clk      in   1       single clock, all logic rising-edge
//  i_rst      in   1       reset, synchronous, active-high
//  i_ready    in   NUM_TR  per-TRID request; bit k = TRID k ready
//  i_rr_mode  in   1       0 = fixed priority, 1 = round robin; sampled each arbitration
//  i_accept   in   1       downstream takes the grant when o_valid & i_accept
//  o_any      out  1       combinational |i_ready
//  o_valid    out  1       registered: o_sel/o_grant hold a live grant
//  o_sel      out  SEL_W   registered granted TRID
//  o_grant    out  NUM_TR  registered one-hot of o_sel; all zero when !o_valid
// BEHAVIOUR
//  Reset: o_valid=0, o_sel=0, o_grant=0, state=IDLE, rr_last=0. o_any stays combinational.
//  FSM: IDLE, GRANT.
//   IDLE: if |req, register winner; next state GRANT, o_valid=1 the following cycle
//    (1-cycle latency from i_ready to o_valid). Else stay IDLE.
//   GRANT: o_sel/o_grant held stable until o_valid & i_accept, even if i_ready changes
//    or i_rr_mode toggles. On accept: rr_last<=o_sel; re-arbitrate the same cycle with the
//    accepted bit masked (req = i_ready & ~o_grant). If req nonzero, stay GRANT with the new
//    winner (back-to-back, no bubble); else go IDLE, o_valid=0.
//  Winner selection:
//   fixed: highest set index of req (15 beats 0 for NUM_TR=16).
//   round robin: scan downward from (rr_last-1) mod NUM_TR, wrapping NUM_TR-1 after 0;
//    first set bit wins. rr_last=0 after reset => first scan starts at NUM_TR-1,
//    identical to fixed mode.
//  rr_last updated only on accept, in both modes (mode switch mid-run is seamless).
//  Granted requester deasserting i_ready before accept: grant still held; downstream decides.
//  Reset mid-GRANT: next cycle outputs return to reset values; pending grant discarded.
//  No combinational path i_accept -> o_valid/o_sel/o_grant.
// STRUCTURE
//  Package rc_arb_pkg: state enum {IDLE, GRANT}; mode localparams ARB_FIXED=0, ARB_RR=1.
//  Sub-module rc_prio_enc #(N): combinational, inputs req[N], start[$clog2(N)];
//   outputs found, idx = first set bit scanning down from start with wraparound.
//   Fixed mode drives start=N-1; RR drives start=rr_last-1 mod N.
//  Top: FSM, rr_last, output registers, masking; prio_enc instantiated once.
// TESTING
//  Reset: i_rst high 2 cycles with i_ready=16'hFFFF -> o_valid=0, o_sel=0, o_grant=0; o_any=1.
//  Fixed: i_rr_mode=0, i_ready=16'h0081, i_accept=1 -> grants 7 then 0 back-to-back, then IDLE.
//  RR fairness: i_rr_mode=1, i_ready=16'h8001 held, i_accept=1 -> o_sel 15,0,15,0 alternating.
//  Hold: i_ready=16'h0010, i_accept=0 5 cycles, then i_ready=16'h8000 -> o_sel stays 4 until
//   accept, then 15.
//  Wrap: RR, rr_last=0 after granting 0, i_ready=16'h0003 -> next grant is 1 (scan wraps from 15).
//  Mid-op reset: assert i_rst during GRANT (o_sel=9) -> next cycle o_valid=0, rr_last=0.

Source files
------------

// File: rtl/rc_arb_pkg.sv
// Shared types for the transaction-ID arbiter.
// FSM state encoding and arbitration mode codes.
package rc_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/rc_prio_enc.sv
// Wrapping priority encoder.
// Finds first set req bit scanning down from start.
module rc_prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  // scan start, start-1, ..., 0, N-1, ... and keep the first hit
  always_comb begin
    int j;
    logic [W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) - i;
      if (j < 0) begin
        j = j + N;
      end
      jj = W'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/tr_arbiter.sv
// Transaction-ID arbiter, fixed or round-robin.
// Registered grant held until downstream accepts.
module tr_arbiter
  import rc_arb_pkg::*;
#(
  parameter int NUM_TR = 16,
  parameter int SEL_W  = $clog2(NUM_TR)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_TR-1:0] i_ready,
  input  logic              i_rr_mode,
  input  logic              i_accept,
  output logic              o_any,
  output logic              o_valid,
  output logic [SEL_W-1:0]  o_sel,
  output logic [NUM_TR-1:0] o_grant
);

  arb_state_e        state;
  logic [SEL_W-1:0]  rr_last;
  logic [SEL_W-1:0]  last_eff;
  logic [SEL_W-1:0]  start;
  logic [NUM_TR-1:0] req;
  logic [NUM_TR-1:0] win_oh;
  logic [SEL_W-1:0]  win;
  logic              found;
  logic              fire;

  localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(NUM_TR - 1);

  assign o_any = |i_ready;
  assign fire  = o_valid & i_accept;

  // re-arbitration after accept excludes the bit just served
  always_comb begin
    req = i_ready;
    if (state == GRANT) begin
      req = i_ready & ~o_grant;
    end
  end

  // on accept the scan already starts below the accepted ID
  always_comb begin
    last_eff = fire ? o_sel : rr_last;
    start    = TOP_IDX;
    if (i_rr_mode == ARB_RR) begin
      if (last_eff == '0) begin
        start = TOP_IDX;
      end else begin
        start = last_eff - SEL_W'(1);
      end
    end
  end

  rc_prio_enc #(
    .N (NUM_TR),
    .W (SEL_W)
  ) u_prio_enc (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  assign win_oh = NUM_TR'(1) << win;

  // grant FSM with registered outputs and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_sel   <= '0;
      o_grant <= '0;
      rr_last <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            o_valid <= 1'b1;
            o_sel   <= win;
            o_grant <= win_oh;
          end
        end
        GRANT: begin
          if (fire) begin
            rr_last <= o_sel;
            if (found) begin
              o_sel   <= win;
              o_grant <= win_oh;
            end else begin
              state   <= IDLE;
              o_valid <= 1'b0;
              o_grant <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tr_arbiter.sv
// Bench for tr_arbiter: directed scenarios then random
// traffic against a rule-level reference model.
module tb_tr_arbiter;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] ready = '0;
  logic         mode = 1'b0;
  logic         accept = 1'b0;
  logic         any;
  logic         valid;
  logic [3:0]   sel;
  logic [N-1:0] grant;

  int vecs = 0;
  int miss = 0;

  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_last  = 0;

  always #5 clk = ~clk;

  tr_arbiter #(.NUM_TR(N)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ready   (ready),
    .i_rr_mode (mode),
    .i_accept  (accept),
    .o_any     (any),
    .o_valid   (valid),
    .o_sel     (sel),
    .o_grant   (grant)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int r, input bit rr,
                              input int last);
    int c;
    if (!rr) begin
      for (int k = N - 1; k >= 0; k--)
        if (((r >> k) & 1) == 1) return k;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (last - k + N) % N;
        if (((r >> c) & 1) == 1) return c;
      end
    end
    return -1;
  endfunction

  task automatic step(input bit r, input logic [N-1:0] rd,
                      input bit md, input bit ac);
    int rem;
    logic [N-1:0] eg;
    @(negedge clk);
    rst    = r;
    ready  = rd;
    mode   = md;
    accept = ac;
    #1;
    chk("any", 32'(any), 32'(|rd));
    if (r) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_last  = 0;
    end else if (!m_valid) begin
      if (rd != '0) begin
        m_sel   = pick(int'(rd), md, m_last);
        m_valid = 1'b1;
      end
    end else if (ac) begin
      m_last = m_sel;
      rem    = int'(rd) & ~(1 << m_sel);
      if (rem != 0) m_sel = pick(rem, md, m_last);
      else m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    eg = m_valid ? N'(1) << m_sel : '0;
    chk("valid", 32'(valid), 32'(m_valid));
    if (m_valid || r) chk("sel", 32'(sel), 32'(m_sel));
    chk("grant", 32'(grant), 32'(eg));
  endtask

  initial begin
    // reset with all requests up
    step(1, 16'hFFFF, 0, 0);
    step(1, 16'hFFFF, 0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_any", 32'(any), 1);

    // fixed priority: 7 then 0 back-to-back, then idle
    step(0, 16'h0081, 0, 1);
    chk("fx_first", 32'(sel), 7);
    step(0, 16'h0001, 0, 1);
    chk("fx_second", 32'(sel), 0);
    chk("fx_b2b", 32'(valid), 1);
    step(0, 16'h0000, 0, 1);
    chk("fx_idle", 32'(valid), 0);

    // round-robin fairness on 15 and 0
    step(1, 16'h0000, 1, 0);
    step(0, 16'h8001, 1, 1);
    chk("rr_0", 32'(sel), 15);
    step(0, 16'h8001, 1, 1);
    chk("rr_1", 32'(sel), 0);
    step(0, 16'h8001, 1, 1);
    chk("rr_2", 32'(sel), 15);
    step(0, 16'h8001, 1, 1);
    chk("rr_3", 32'(sel), 0);

    // hold while not accepted
    step(1, 16'h0000, 0, 0);
    step(0, 16'h0010, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 16'h0010, 0, 0);
    step(0, 16'h8000, 0, 0);
    chk("hold", 32'(sel), 4);
    step(0, 16'h8000, 0, 1);
    chk("hold_next", 32'(sel), 15);

    // wraparound from rr_last=0
    step(1, 16'h0000, 1, 0);
    step(0, 16'h0001, 1, 0);
    step(0, 16'h0000, 1, 1);
    chk("wrap_idle", 32'(valid), 0);
    step(0, 16'h0003, 1, 0);
    chk("wrap", 32'(sel), 1);

    // reset in the middle of a grant
    step(1, 16'h0000, 1, 0);
    step(0, 16'h0200, 1, 0);
    step(0, 16'h0000, 1, 1);
    step(0, 16'h0200, 1, 0);
    chk("mid_g", 32'(sel), 9);
    step(1, 16'h0200, 1, 0);
    chk("mid_rst", 32'(valid), 0);
    step(0, 16'h8020, 1, 0);
    chk("mid_ptr", 32'(sel), 15);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] rd;
      bit rr;
      rd = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 7) == 0) rd = '0;
      rr = ($urandom_range(0, 3) != 0) ? mode : 1'($urandom);
      step($urandom_range(0, 59) == 0, rd, rr,
           1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
